// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer.
// Defines the FIFO entry layout and the word-address LSB position.
package store_buffer_pkg;

    // Bit position where the word address starts within a byte address.
    localparam int WORD_LSB = 2;

    // One pending store; is_byte selects an sb (data in [7:0]).
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } sbuf_entry_t;

endpackage

// File: rtl/store_buffer.sv
// Posted-write buffer between memory-stage requests and data memory.
// Ports: clk/reset; st_* store request in; ld_* load in, ld_stall/ld_data out;
// mem_* single-port memory side; empty/count occupancy status.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic          st_byte,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_stall,
    output logic [31:0]   ld_data,
    output logic          mem_we,
    output logic          mem_sb,
    output logic [31:0]   mem_a,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    sbuf_entry_t      entries [DEPTH];
    sbuf_entry_t      head_e;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] hits;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             enq;
    logic             do_load;
    logic             do_drain;

    // Only entries latched before this edge are compared, so a store
    // accepted in the same cycle as a load never stalls that load.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hits[i] = valid[i] &&
            (entries[i].addr[31:WORD_LSB] == ld_addr[31:WORD_LSB]);
    end

    assign head_e   = entries[head];
    assign empty    = (count == '0);
    assign st_ready = (count != CW'(DEPTH));
    assign enq      = st_valid && st_ready;
    assign ld_stall = ld_valid && (|hits);
    assign do_load  = ld_valid && !ld_stall;
    // Reset gates the drain so no write reaches memory while in reset.
    assign do_drain = !empty && !do_load && !reset;
    assign ld_data  = mem_rd;

    always_comb begin
        mem_we = 1'b0;
        mem_sb = 1'b0;
        mem_a  = ld_addr;
        mem_wd = '0;
        if (do_drain) begin
            mem_we = 1'b1;
            mem_sb = head_e.is_byte;
            mem_a  = head_e.addr;
            mem_wd = head_e.data;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr: st_addr, data: st_data,
                               is_byte: st_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            // A non-full buffer with head == tail is empty, so enq and
            // drain never touch the same slot in one cycle.
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            if (do_drain) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            unique case ({enq, do_drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Includes a big-endian byte-lane memory model on the mem_* port.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_byte = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_stall;
    logic [31:0] ld_data;
    logic        mem_we;
    logic        mem_sb;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int nwr = 0;
    logic [31:0] wr_a [64];
    logic [31:0] wr_d [64];
    logic [31:0] mem [64];

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_stall(ld_stall), .ld_data(ld_data),
        .mem_we(mem_we), .mem_sb(mem_sb),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            if (nwr < 64) begin
                wr_a[nwr] = mem_a;
                wr_d[nwr] = mem_wd;
            end
            nwr = nwr + 1;
            if (!mem_sb) mem[mem_a[7:2]] = mem_wd;
            else begin
                case (mem_a[1:0])
                    2'd0: mem[mem_a[7:2]][31:24] = mem_wd[7:0];
                    2'd1: mem[mem_a[7:2]][23:16] = mem_wd[7:0];
                    2'd2: mem[mem_a[7:2]][15:8]  = mem_wd[7:0];
                    default: mem[mem_a[7:2]][7:0] = mem_wd[7:0];
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic b);
        st_valid = 1'b1; st_addr = a; st_data = d; st_byte = b;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({st_ready, empty, count, mem_we, mem_sb, ld_stall}
            !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b emp=%b cnt=%0d we=%b sb=%b stall=%b",
                     st_ready, empty, count, mem_we, mem_sb, ld_stall);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_we !== 1'b0 || empty !== 1'b1) begin
                errors++;
                $display("FAIL idle_we cycle %0d we=%b emp=%b want 0,1",
                         i, mem_we, empty);
            end
        end
        ld_valid = 1'b1; ld_addr = 32'h100;
        store(32'h80, 32'h1, 1'b0);
        store(32'h84, 32'h2, 1'b0);
        store(32'h88, 32'h3, 1'b0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_count got %0d want 3", count);
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write we=%b want 0", mem_we);
        end
        n0 = nwr;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || nwr !== n0) begin
            errors++;
            $display("FAIL post_reset cnt=%0d emp=%b writes=%0d want 0,1,%0d",
                     count, empty, nwr, n0);
        end
    endtask

    task automatic test_single_word();
        st_valid = 1'b1; st_addr = 32'h10;
        st_data = 32'hDEAD_BEEF; st_byte = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL sw_not_early we=%b want 0", mem_we);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_sb, mem_a, mem_wd}
            !== {1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sw_drain we=%b sb=%b a=%h wd=%h want 1,0,10,deadbeef",
                     mem_we, mem_sb, mem_a, mem_wd);
        end
        tick();
        ld_valid = 1'b1; ld_addr = 32'h10;
        #1;
        checks++;
        if ({ld_stall, mem_we, ld_data} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sw_load stall=%b we=%b data=%h want 0,0,deadbeef",
                     ld_stall, mem_we, ld_data);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_byte_store();
        store(32'h10, 32'h0, 1'b0);
        store(32'h11, 32'h1234_56AB, 1'b1);
        #1;
        checks++;
        if ({mem_we, mem_sb, mem_a, mem_wd}
            !== {1'b1, 1'b1, 32'h11, 32'h1234_56AB}) begin
            errors++;
            $display("FAIL sb_drain we=%b sb=%b a=%h wd=%h want 1,1,11,123456ab",
                     mem_we, mem_sb, mem_a, mem_wd);
        end
        tick(); tick();
        ld_valid = 1'b1; ld_addr = 32'h10;
        #1;
        checks++;
        if (ld_data !== 32'h00AB_0000 || empty !== 1'b1) begin
            errors++;
            $display("FAIL sb_load data=%h emp=%b want 00ab0000,1",
                     ld_data, empty);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_fill();
        ld_valid = 1'b1; ld_addr = 32'h100;
        for (int i = 0; i < 4; i++)
            store(32'h40 + 32'(4 * i), 32'(i + 1), 1'b0);
        checks++;
        if ({count, st_ready, mem_we} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fill_full cnt=%0d rdy=%b we=%b want 4,0,0",
                     count, st_ready, mem_we);
        end
        store(32'h50, 32'h5, 1'b0);
        checks++;
        if (count !== 3'd4 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fill_reject cnt=%0d we=%b want 4,0", count, mem_we);
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({mem_we, mem_a, mem_wd}
                !== {1'b1, 32'h40 + 32'(4 * i), 32'(i + 1)}) begin
                errors++;
                $display("FAIL fill_drain %0d we=%b a=%h wd=%h want 1,%h,%h",
                         i, mem_we, mem_a, mem_wd,
                         32'h40 + 32'(4 * i), 32'(i + 1));
            end
            tick();
            if (i == 0) begin
                checks++;
                if (st_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_ready got %b want 1", st_ready);
                end
            end
        end
        checks++;
        if (empty !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty emp=%b we=%b want 1,0", empty, mem_we);
        end
    endtask

    task automatic test_hazard();
        ld_valid = 1'b1; ld_addr = 32'h20;
        st_valid = 1'b1; st_addr = 32'h20;
        st_data = 32'hAAAA_0020; st_byte = 1'b0;
        #1;
        checks++;
        if (ld_stall !== 1'b0) begin
            errors++;
            $display("FAIL hz_same_cycle stall=%b want 0", ld_stall);
        end
        tick();
        ld_addr = 32'h100;
        store(32'h24, 32'hBBBB_0024, 1'b0);
        ld_addr = 32'h23;
        #1;
        checks++;
        if ({ld_stall, mem_we, mem_a, count}
            !== {1'b1, 1'b1, 32'h20, 3'd2}) begin
            errors++;
            $display("FAIL hz_stall stall=%b we=%b a=%h cnt=%0d want 1,1,20,2",
                     ld_stall, mem_we, mem_a, count);
        end
        tick();
        checks++;
        if ({ld_stall, mem_we, ld_data, count}
            !== {1'b0, 1'b0, 32'hAAAA_0020, 3'd1}) begin
            errors++;
            $display("FAIL hz_release stall=%b we=%b data=%h cnt=%0d want 0,0,aaaa0020,1",
                     ld_stall, mem_we, ld_data, count);
        end
        ld_valid = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1 || mem[9] !== 32'hBBBB_0024) begin
            errors++;
            $display("FAIL hz_tail emp=%b mem24=%h want 1,bbbb0024",
                     empty, mem[9]);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        ld_valid = 1'b1; ld_addr = 32'h100;
        store(32'h60, 32'hC0, 1'b0);
        store(32'h64, 32'hC1, 1'b0);
        ld_valid = 1'b0;
        n0 = nwr;
        store(32'h68, 32'hC2, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL b2b_count1 got %0d want 2", count);
        end
        store(32'h6C, 32'hC3, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL b2b_count2 got %0d want 2", count);
        end
        for (int i = 0; i < 8 && !empty; i++) tick();
        checks++;
        if (empty !== 1'b1 || nwr - n0 !== 4) begin
            errors++;
            $display("FAIL b2b_drain emp=%b writes=%0d want 1,4",
                     empty, nwr - n0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (n0 + i >= 64 || wr_a[n0 + i] !== 32'h60 + 32'(4 * i)
                || wr_d[n0 + i] !== 32'hC0 + 32'(i)) begin
                errors++;
                $display("FAIL b2b_order %0d a=%h d=%h want %h,%h", i,
                         wr_a[(n0 + i) % 64], wr_d[(n0 + i) % 64],
                         32'h60 + 32'(4 * i), 32'hC0 + 32'(i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_single_word();
        test_byte_store();
        test_fill();
        test_hazard();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the processor's memory-stage store/load requests and the single-port data memory. Holds up to DEPTH pending word or byte stores and retires them in order, one per cycle. Loads always take priority on the memory port. A load stalls only if its word address matches a pending store. This takes store write latency off the pipeline's critical path while keeping memory-consistent loads.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2
- CW, $clog2(DEPTH)+1: width of `count`
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- st_valid  in  1  store request from pipeline
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  store byte address
- st_data  in  32  store data; byte stores use st_data[7:0]
- st_byte  in  1  1 = byte store (sb), 0 = word store
- ld_valid  in  1  load request from pipeline
- ld_addr  in  32  load byte address
- ld_stall  out  1  load blocked by a pending store to the same word
- ld_data  out  32  load data (mem_rd passthrough)
- mem_we, mem_sb  out  1  memory write enable / byte-store select
- mem_a, mem_wd  out  32  memory address / write data
- mem_rd  in  32  memory combinational read data
- empty  out  1  no pending stores
- count  out  CW  number of pending stores

## Operation
- Circular FIFO of entries {addr[31:0], data[31:0], byte}, with head/tail pointers and an occupancy count.
- Enqueue when st_valid && st_ready. st_ready = (count != DEPTH).
  - No enqueue on a full buffer, even if a drain happens in the same cycle.
- Hazard check:
  - ld_stall = ld_valid && (any valid entry has addr[31:2] == ld_addr[31:2]).
  - Comparison is at word granularity. Byte offsets are ignored, so the check is conservative.
- Port arbitration, combinational:
  - Load (ld_valid && !ld_stall): mem_a = ld_addr, mem_we = 0, mem_sb = 0. No drain this cycle.
  - Drain (!empty && (!ld_valid || ld_stall)): mem_a = head.addr, mem_wd = head.data, mem_sb = head.byte, mem_we = 1. Head advances at the edge.
  - Idle: mem_we = 0, mem_a = ld_addr.
- A stalled load never blocks the drain, so it clears in at most count cycles.
- ld_data = mem_rd in all cases. It is only meaningful when ld_valid && !ld_stall.
- Byte stores pass through unmodified, with the byte lane selected by the memory using big-endian order:
  - offset 00 → bits [31:24]
  - offset 11 → bits [7:0]
- st_valid and ld_valid are normally exclusive. If both are asserted:
  - the store is enqueued;
  - the load is checked only against entries present before that edge, i.e. the load is older.
- count: enqueue only → +1; drain only → −1; both → unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Reset:
  - head = tail = 0, count = 0, all entries invalid, pending stores discarded.
  - Resulting outputs: st_ready = 1, empty = 1, ld_stall = 0, mem_we = 0, mem_sb = 0.
  - mem_we is forced to 0 in any cycle where reset = 1, so no memory write occurs during reset.
- Store latency: a store accepted at edge N is visible at head no earlier than the cycle after edge N. Its memory write commits at edge N+1 at the earliest.
- Drain throughput: one entry per cycle when no loads compete.
- Load latency: zero added cycles when not stalled, since read data is combinational.
- Stall duration for a matching load: cycles until the last matching entry drains. ld_stall drops the cycle after that drain edge.
- A store is not visible to the hazard check in its own acceptance cycle.
- Full → st_ready low. It returns high the cycle after the first drain edge.

## Structure
- Package store_buffer_pkg:
  - typedef sbuf_entry_t (packed: addr, data, byte)
  - localparam WORD_LSB = 2
- Entry storage, pointers and the hazard comparison (a generate loop over DEPTH valid bits) all live in one module. No sub-module is required.

## Test plan
- Reset then idle:
  - Required: st_ready = 1, empty = 1, count = 0, mem_we = 0 every cycle.
  - Assert reset mid-drain with 3 entries pending → no write during the reset cycle, and count = 0 after.
- Single word store:
  - Stimulus: st 0x0000_0010 ← 0xDEAD_BEEF at edge 0.
  - Required: cycle 1 has mem_we = 1, mem_a = 0x10, mem_sb = 0. A load of 0x10 on cycle 2 returns 0xDEAD_BEEF.
- Byte store:
  - Stimulus: word 0x10 = 0x0000_0000, then sb 0x11 ← 0x...AB.
  - Required: a later load of 0x10 returns 0x00AB_0000.
- Fill to DEPTH = 4 with ld_valid held high to non-matching address 0x100:
  - Required: count = 4, st_ready = 0, no drain while the load continues.
  - Drop ld_valid → 4 consecutive mem_we cycles in FIFO order, then empty = 1.
- Hazard:
  - Stimulus: pending stores to 0x20 and 0x24, then a load of 0x23.
  - Required: ld_stall = 1 during the 0x20 drain, and 0 the next cycle. The load returns the newly written data without waiting for 0x24.
- Simultaneous enqueue and drain at count = 2 → count stays 2. Pointer wrap after 6 total stores preserves order.
